apb_mem_slave: RTL and testbench



---
 rtl/apb_mem_slave.sv | 123 ++++++++++++
 tb/tb_apb_mem_slave.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/apb_mem_slave.sv
// APB4 completer in front of a word-addressed RAM with byte strobes,
// programmable PREADY wait states and PSLVERR on misaligned/out-of-range accesses.
`timescale 1ns/1ps
module apb_mem_slave #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0,
  parameter int ERR_EN      = 1
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
  input  logic                    PWRITE,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR
);

  localparam int NB     = DATA_WIDTH / 8;
  localparam int BL     = $clog2(NB);
  localparam int IW     = $clog2(DEPTH);
  localparam int BL_MSB = (BL > 0) ? BL - 1 : 0;
  localparam int HI_LSB = (BL + IW < ADDR_WIDTH) ? BL + IW : ADDR_WIDTH - 1;

  if (DATA_WIDTH != 8 && DATA_WIDTH != 16 && DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_dw
    $error("apb_mem_slave: DATA_WIDTH must be 8, 16, 32 or 64");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("apb_mem_slave: DEPTH must be a power of two >= 2");
  end
  if (WAIT_STATES < 0 || WAIT_STATES > 255) begin : g_bad_ws
    $error("apb_mem_slave: WAIT_STATES must be 0..255");
  end

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t                state, state_next;
  logic [7:0]            wcnt, wcnt_next;
  logic                  misaligned, out_of_range, err;
  logic [IW-1:0]         idx;
  logic                  access;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  assign idx = PADDR[BL +: IW];

  if (BL == 0) begin : g_no_align
    assign misaligned = 1'b0;
  end else begin : g_align
    assign misaligned = |PADDR[BL_MSB:0];
  end

  // When the index plus byte-lane bits cover all of PADDR, nothing can be out of range.
  if (BL + IW >= ADDR_WIDTH) begin : g_no_range
    assign out_of_range = 1'b0;
  end else begin : g_range
    assign out_of_range = |PADDR[ADDR_WIDTH-1:HI_LSB];
  end

  assign err    = misaligned | out_of_range;
  assign access = PSEL & PENABLE;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state <= IDLE;
      wcnt  <= 8'd0;
    end else begin
      state <= state_next;
      wcnt  <= wcnt_next;
    end
  end

  always_comb begin
    state_next = state;
    wcnt_next  = wcnt;
    PREADY     = 1'b0;
    case (state)
      IDLE: begin
        if (PSEL && !PENABLE) begin
          wcnt_next  = 8'(WAIT_STATES);
          state_next = (WAIT_STATES == 0) ? DONE : WAIT;
        end
      end
      WAIT: begin
        if (!PSEL) begin
          state_next = IDLE;
        end else if (PENABLE) begin
          wcnt_next = wcnt - 8'd1;
          if (wcnt == 8'd1) state_next = DONE;
        end
      end
      DONE: begin
        if (!PSEL) begin
          state_next = IDLE;
        end else if (PENABLE) begin
          PREADY     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Errored writes are dropped regardless of ERR_EN; ERR_EN only masks the response.
  assign wr_en   = PREADY & PWRITE & ~err;
  assign PSLVERR = err & (ERR_EN != 0) & PREADY;
  assign PRDATA  = (PREADY && !PWRITE && !err) ? mem[idx] : '0;

  // Storage has no reset so contents survive PRESETn.
  always_ff @(posedge PCLK) begin
    if (wr_en) begin
      for (int b = 0; b < NB; b++) begin
        if (PSTRB[b]) mem[idx][8*b +: 8] <= PWDATA[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_apb_mem_slave.sv
// Directed bench for apb_mem_slave: four configurations on one shared APB bus,
// selected individually through their PSEL lines.
`timescale 1ns/1ps
module tb_apb_mem_slave;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] paddr;
  logic [63:0] pwdata;
  logic [7:0]  pstrb;
  logic        pwrite, penable;
  logic [3:0]  psel;
  logic [31:0] prdata0, prdata1, prdata2;
  logic [63:0] prdata3;
  logic [3:0]  pready, pslverr;

  int          cur;
  logic [63:0] cur_prdata;
  logic        cur_pready, cur_pslverr;
  int          errors = 0;
  int          checks = 0;
  logic        leak_seen = 1'b0;

  always #5 clk = ~clk;

  // u0 defaults, u1 three wait states, u2 errors masked, u3 64-bit x 16.
  apb_mem_slave u0 (
    .PCLK(clk), .PRESETn(rst_n), .PADDR(paddr), .PWDATA(pwdata[31:0]), .PSTRB(pstrb[3:0]),
    .PWRITE(pwrite), .PSEL(psel[0]), .PENABLE(penable),
    .PRDATA(prdata0), .PREADY(pready[0]), .PSLVERR(pslverr[0]));
  apb_mem_slave #(.WAIT_STATES(3)) u1 (
    .PCLK(clk), .PRESETn(rst_n), .PADDR(paddr), .PWDATA(pwdata[31:0]), .PSTRB(pstrb[3:0]),
    .PWRITE(pwrite), .PSEL(psel[1]), .PENABLE(penable),
    .PRDATA(prdata1), .PREADY(pready[1]), .PSLVERR(pslverr[1]));
  apb_mem_slave #(.ERR_EN(0)) u2 (
    .PCLK(clk), .PRESETn(rst_n), .PADDR(paddr), .PWDATA(pwdata[31:0]), .PSTRB(pstrb[3:0]),
    .PWRITE(pwrite), .PSEL(psel[2]), .PENABLE(penable),
    .PRDATA(prdata2), .PREADY(pready[2]), .PSLVERR(pslverr[2]));
  apb_mem_slave #(.DATA_WIDTH(64), .DEPTH(16)) u3 (
    .PCLK(clk), .PRESETn(rst_n), .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
    .PWRITE(pwrite), .PSEL(psel[3]), .PENABLE(penable),
    .PRDATA(prdata3), .PREADY(pready[3]), .PSLVERR(pslverr[3]));

  always_comb begin
    cur_prdata  = '0;
    cur_pready  = pready[cur];
    cur_pslverr = pslverr[cur];
    case (cur)
      0:       cur_prdata = {32'd0, prdata0};
      1:       cur_prdata = {32'd0, prdata1};
      2:       cur_prdata = {32'd0, prdata2};
      default: cur_prdata = prdata3;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Starts a setup phase in the current cycle; returns #1 after the completion edge
  // with the bus idle, so consecutive calls are back-to-back transfers.
  task automatic xfer(input int k, input logic wr, input logic [31:0] addr,
                      input logic [63:0] data, input logic [7:0] strb,
                      output logic [63:0] rd, output logic er, output int waits);
    cur     = k;
    paddr   = addr;
    pwrite  = wr;
    pwdata  = data;
    pstrb   = strb;
    psel    = 4'b0;
    psel[k] = 1'b1;
    penable = 1'b0;
    @(posedge clk);
    #1 penable = 1'b1;
    waits = 0;
    #1;
    while (!cur_pready && waits < 300) begin
      if (cur_prdata !== 64'd0 || cur_pslverr !== 1'b0) leak_seen = 1'b1;
      waits++;
      @(posedge clk);
      #1;
    end
    rd = cur_prdata;
    er = cur_pslverr;
    @(posedge clk);
    #1;
    psel    = 4'b0;
    penable = 1'b0;
  endtask

  function automatic int exp_waits(input int k);
    return (k == 1) ? 3 : 0;
  endfunction

  task automatic wr(input string tag, input int k, input logic [31:0] addr,
                    input logic [63:0] data, input logic [7:0] strb, input logic exp_err);
    logic [63:0] rd;
    logic        er;
    int          w;
    xfer(k, 1'b1, addr, data, strb, rd, er, w);
    check({tag, "_waits"}, 64'(w), 64'(exp_waits(k)));
    check({tag, "_err"}, 64'(er), 64'(exp_err));
    check({tag, "_prdata"}, rd, 64'd0);
  endtask

  task automatic rd(input string tag, input int k, input logic [31:0] addr,
                    input logic [63:0] exp_data, input logic exp_err);
    logic [63:0] d;
    logic        er;
    int          w;
    xfer(k, 1'b0, addr, 64'd0, 8'hFF, d, er, w);
    check({tag, "_waits"}, 64'(w), 64'(exp_waits(k)));
    check({tag, "_err"}, 64'(er), 64'(exp_err));
    check({tag, "_data"}, d, exp_data);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    paddr   = '0;
    pwdata  = '0;
    pstrb   = '0;
    pwrite  = 1'b0;
    penable = 1'b0;
    psel    = 4'b0;
    cur     = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pready", 64'(pready), 64'd0);
    check("rst_pslverr", 64'(pslverr), 64'd0);
    check("rst_prdata0", 64'(prdata0), 64'd0);
    check("rst_prdata3", prdata3, 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic write/read, zero wait states.
    wr("u0_wr10", 0, 32'h10, 64'hDEADBEEF, 8'hF, 1'b0);
    rd("u0_rd10", 0, 32'h10, 64'hDEADBEEF, 1'b0);

    // Byte strobes, then an all-zero strobe that must leave the word alone.
    wr("u0_wr20_full", 0, 32'h20, 64'hFFFFFFFF, 8'hF, 1'b0);
    wr("u0_wr20_strb5", 0, 32'h20, 64'h11223344, 8'h5, 1'b0);
    rd("u0_rd20", 0, 32'h20, 64'hFF22FF44, 1'b0);
    wr("u0_wr20_strb0", 0, 32'h20, 64'h00000000, 8'h0, 1'b0);
    rd("u0_rd20_again", 0, 32'h20, 64'hFF22FF44, 1'b0);

    // Error responses; 0x13 aliases word 4 (0x10) if alignment were ignored.
    rd("u0_rd400", 0, 32'h400, 64'd0, 1'b1);
    wr("u0_wr13", 0, 32'h13, 64'h0BADF00D, 8'hF, 1'b1);
    rd("u0_rd10_kept", 0, 32'h10, 64'hDEADBEEF, 1'b0);
    rd("u0_rd12_mis", 0, 32'h12, 64'd0, 1'b1);

    // Three wait states; PRDATA/PSLVERR must stay low while PREADY is low.
    leak_seen = 1'b0;
    wr("u1_wr08", 1, 32'h08, 64'hCAFEF00D, 8'hF, 1'b0);
    rd("u1_rd08", 1, 32'h08, 64'hCAFEF00D, 1'b0);
    check("u1_wait_leak", 64'(leak_seen), 64'd0);
    wr("u1_wr40", 1, 32'h40, 64'hAAAA5555, 8'hF, 1'b0);

    // Reset pulse in the middle of a waited write: no completion, no write.
    cur     = 1;
    paddr   = 32'h40;
    pwrite  = 1'b1;
    pwdata  = 64'h12345678;
    pstrb   = 8'hF;
    psel    = 4'b0010;
    penable = 1'b0;
    @(posedge clk);
    #1 penable = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check("u1_rst_pready_now", 64'(pready[1]), 64'd0);
    @(posedge clk);
    #1 check("u1_rst_pready_held", 64'(pready[1]), 64'd0);
    psel    = 4'b0;
    penable = 1'b0;
    rst_n   = 1'b1;
    @(posedge clk);
    #1;
    rd("u1_rd40_after_rst", 1, 32'h40, 64'hAAAA5555, 1'b0);

    // PSEL dropped during the wait phase aborts the write.
    paddr   = 32'h40;
    pwrite  = 1'b1;
    pwdata  = 64'hBBBBBBBB;
    psel    = 4'b0010;
    penable = 1'b0;
    @(posedge clk);
    #1 penable = 1'b1;
    @(posedge clk);
    #1;
    psel    = 4'b0;
    penable = 1'b0;
    @(posedge clk);
    #1;
    rd("u1_rd40_after_abort", 1, 32'h40, 64'hAAAA5555, 1'b0);

    // ERR_EN=0: bad accesses report OK but still must not touch word 0 (their alias).
    wr("u2_wr00", 2, 32'h00, 64'h5A5A5A5A, 8'hF, 1'b0);
    wr("u2_wr400", 2, 32'h400, 64'h77777777, 8'hF, 1'b0);
    wr("u2_wr01", 2, 32'h01, 64'h66666666, 8'hF, 1'b0);
    rd("u2_rd00", 2, 32'h00, 64'h5A5A5A5A, 1'b0);
    rd("u2_rd400", 2, 32'h400, 64'd0, 1'b0);

    // 64-bit, 16 words: back-to-back writes at both ends, then errors at 0x80 (aliases word 0).
    wr("u3_wr00", 3, 32'h00, 64'h0123456789ABCDEF, 8'hFF, 1'b0);
    wr("u3_wr78", 3, 32'h78, 64'hFEDCBA9876543210, 8'hFF, 1'b0);
    rd("u3_rd00", 3, 32'h00, 64'h0123456789ABCDEF, 1'b0);
    rd("u3_rd78", 3, 32'h78, 64'hFEDCBA9876543210, 1'b0);
    wr("u3_wr80", 3, 32'h80, 64'h1111111111111111, 8'hFF, 1'b1);
    rd("u3_rd80", 3, 32'h80, 64'd0, 1'b1);
    rd("u3_rd04_mis", 3, 32'h04, 64'd0, 1'b1);
    rd("u3_rd00_kept", 3, 32'h00, 64'h0123456789ABCDEF, 1'b0);
    wr("u3_wr78_lo", 3, 32'h78, 64'h0, 8'h0F, 1'b0);
    rd("u3_rd78_lo", 3, 32'h78, 64'hFEDCBA9800000000, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
